// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller:
//   - access-code constants (same encoding as the legacy zero-latency RAM)
//   - controller FSM state enum
//   - access_legal(): screens access codes that do not exist for the
//     requested direction (loads accept all five codes, stores only B/H/W)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsigned variants only make sense for loads; codes 011/110/111 are
    // never legal.
    function automatic logic access_legal(input logic we, input logic [2:0] access);
        logic legal;
        case (access)
            ACC_B, ACC_H, ACC_W: legal = 1'b1;
            ACC_BU, ACC_HU:      legal = ~we;
            default:             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True when the low address bits do not match the natural alignment of
    // the access size. Only consulted when misalignment trapping is built in.
    function automatic logic access_misaligned(input logic [2:0] access,
                                               input logic [1:0] byte_off);
        logic mis;
        case (access[1:0])
            2'b01:   mis = byte_off[0];
            2'b10:   mis = (byte_off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering shared by the store and load paths.
//
// Ports:
//   access      in  3   access code (B/H/W/BU/HU)
//   byte_off    in  2   low two bits of the byte address
//   store_data  in  32  right-aligned store data
//   load_word   in  32  full word read from the array
//   byte_we     out 4   per-lane write enables for a store
//   store_word  out 32  store data replicated onto every candidate lane
//   load_data   out 32  addressed byte/half extracted and sign/zero-extended
//
// Half accesses always use lanes {byte_off[1],0} and word accesses lane 0,
// so misaligned low bits are truncated here; trapping them is the caller's
// decision.
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  access,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_we,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store path: replicating the byte/half across the word means the
    // enable mask alone decides which lane actually receives it.
    always_comb begin
        byte_we    = 4'b0000;
        store_word = store_data;
        case (access[1:0])
            2'b00: begin
                byte_we    = 4'b0001 << byte_off;
                store_word = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_we    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
            end
            2'b10: begin
                byte_we    = 4'b1111;
                store_word = store_data;
            end
            default: byte_we = 4'b0000;
        endcase
    end

    // Load path: pick the addressed byte and half, then extend according
    // to the signed/unsigned flavour of the access code.
    always_comb begin
        sel_byte = load_word[7:0];
        case (byte_off)
            2'd0: sel_byte = load_word[7:0];
            2'd1: sel_byte = load_word[15:8];
            2'd2: sel_byte = load_word[23:16];
            2'd3: sel_byte = load_word[31:24];
            default: sel_byte = load_word[7:0];
        endcase
        sel_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

        load_data = load_word;
        case (access)
            ACC_B:   load_data = {{24{sel_byte[7]}}, sel_byte};
            ACC_BU:  load_data = {24'h000000, sel_byte};
            ACC_H:   load_data = {{16{sel_half[15]}}, sel_half};
            ACC_HU:  load_data = {16'h0000, sel_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Parametrised data-memory controller for the RV32 load/store path.
// One request in flight at a time: accept -> wait-state countdown -> single
// array access -> response held until the consumer takes it.
//
// Parameters:
//   ADDR_W       word-index width, depth = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra cycles between accept and array access (0..15)
//   INIT_FILE    hex image loaded into the array at elaboration ("" = none)
//
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   asynchronous active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   request can be accepted this cycle
//   req_we      in  1   1 = store, 0 = load
//   req_access  in  3   access code
//   req_addr    in  32  byte address
//   req_wdata   in  32  right-aligned store data
//   rsp_valid   out 1   response present
//   rsp_ready   in  1   consumer accepts response
//   rsp_rdata   out 32  extended load data; 0 for stores and faults
//   rsp_err     out 1   request faulted, array untouched
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault
//                          instead of silently truncating the low bits.
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int    ADDR_W      = 11,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic                accept;
    logic                do_access;

    logic                lat_we;
    logic [2:0]          lat_access;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_word;
    logic                err_q;

    logic                range_fault;
    logic                code_fault;
    logic                align_fault;
    logic                req_fault;
    logic [ADDR_W-1:0]   word_idx;

    logic [3:0]          byte_we;
    logic [31:0]         store_word;
    logic [31:0]         load_data;

    // Fault classification works on the latched request so it stays stable
    // across the whole wait period and the response.
    always_comb begin
        range_fault = ((lat_addr >> (ADDR_W + 2)) != 32'd0);
        code_fault  = ~access_legal(lat_we, lat_access);
`ifdef DMEM_MISALIGN_TRAP_EN
        align_fault = access_misaligned(lat_access, lat_addr[1:0]);
`else
        align_fault = 1'b0;
`endif
        req_fault   = range_fault | code_fault | align_fault;
        word_idx    = lat_addr[ADDR_W+1:2];
    end

    dmem_lane_align u_lane_align (
        .access     (lat_access),
        .byte_off   (lat_addr[1:0]),
        .store_data (lat_wdata),
        .load_word  (rd_word),
        .byte_we    (byte_we),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake logic. A request accepted in RESP (while the
    // response is being consumed) goes straight into WAIT for back-to-back
    // turnaround. With WAIT_CYCLES=0 the counter enters WAIT at zero, so the
    // array access lands on the very next edge.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    req_ready  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rst) begin
            req_ready = 1'b0;
        end
        accept = req_valid & req_ready;
        if (accept) begin
            state_next = WAIT;
        end
    end

    // Request latch, wait counter and read/fault capture. The read word is
    // registered whole; lane extraction happens afterwards on the held copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we     <= 1'b0;
            lat_access <= ACC_W;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            wait_cnt   <= 4'd0;
            rd_word    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                lat_we     <= req_we;
                lat_access <= req_access;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                wait_cnt   <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (do_access) begin
                err_q   <= req_fault;
                rd_word <= mem[word_idx];
            end
        end
    end

    // Array write port. Deliberately unreset so contents survive reset; an
    // asserted reset forces IDLE, which suppresses do_access and therefore
    // drops any store that has not reached its commit edge yet.
    always_ff @(posedge clk) begin
        if (do_access && lat_we && !req_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_we[i]) begin
                    mem[word_idx][i*8 +: 8] <= store_word[i*8 +: 8];
                end
            end
        end
    end

    // Response fields only read as non-zero while a response is presented.
    always_comb begin
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        if (state == RESP) begin
            rsp_err = err_q;
            if (!err_q && !lat_we) begin
                rsp_rdata = load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Two controller instances (WAIT_CYCLES 0 and 3) driven by a directed vector
// table, a few hand-built multi-cycle sequences, and randomized traffic
// checked against a byte-addressed little-endian memory model.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_access [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int checks = 0;
    int fails  = 0;
    int wait_of [2] = '{0, 3};

    logic [7:0] mb [2][8192];
    vec_t       tbl [$];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(11), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_access(req_access[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.ADDR_W(11), .WAIT_CYCLES(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_access(req_access[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] acc,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = name; v.we = we; v.acc = acc; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Reference model: byte-addressed memory, sizes 1/2/4, aligned down to
    // the access size, little-endian assembly, sign extension for signed loads.
    task automatic modelAccess(input int d, input logic we, input logic [2:0] acc,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err);
        int size;
        int base;
        logic [31:0] v;
        rd  = 32'd0;
        err = 1'b0;
        if (addr >= 32'd8192) err = 1'b1;
        if (acc == 3'd3 || acc == 3'd6 || acc == 3'd7) err = 1'b1;
        if (we && acc[2]) err = 1'b1;
        if (err) return;
        size = (acc[1:0] == 2'd0) ? 1 : (acc[1:0] == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((int'(addr) % size) != 0) begin
            err = 1'b1;
            return;
        end
`endif
        base = int'(addr) - (int'(addr) % size);
        if (we) begin
            for (int k = 0; k < size; k++) mb[d][base+k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = mb[d][base+k];
            if (!acc[2] && size < 4 && v[8*size-1]) begin
                for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            rd = v;
        end
    endtask

    task automatic mkModel(input int d, input string name, input logic we, input logic [2:0] acc,
                           input logic [31:0] addr, input logic [31:0] wd, output vec_t v);
        logic [31:0] rd;
        logic er;
        modelAccess(d, we, acc, addr, wd, rd, er);
        v = mk(name, we, acc, addr, wd, rd, er);
    endtask

    // Present the request and return once the accepting edge has passed.
    task automatic issueReq(input int d, input vec_t v, output bit ok);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = v.we; req_access[d] = v.acc;
        req_addr[d] = v.addr; req_wdata[d] = v.wdata;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[d]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checkOutput({v.name, "_accept"}, 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    // Counts edges after accept until rsp_valid, then checks latency.
    task automatic waitRsp(input int d, input string name);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid[d]) break;
        end
        checkOutput({name, "_lat"}, lat, 1 + wait_of[d]);
    endtask

    task automatic holdCheck(input int d, input vec_t v, input int hold);
        for (int h = 0; h <= hold; h++) begin
            checkOutput({v.name, "_rdata"}, rsp_rdata[d], v.exp_rdata);
            checkOutput({v.name, "_err"}, rsp_err[d], v.exp_err);
            if (h < hold) begin
                @(posedge clk); #1;
                checkOutput({v.name, "_vhold"}, rsp_valid[d], 1);
            end
        end
    endtask

    task automatic applyStimulus(input int d, input vec_t v, input int hold);
        bit ok;
        issueReq(d, v, ok);
        if (!ok) return;
        waitRsp(d, v.name);
        holdCheck(d, v, hold);
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        checkOutput({v.name, "_vdrop"}, rsp_valid[d], 0);
    endtask

    // Second request is offered in the same cycle the first response is taken.
    task automatic backToBack(input int d, input vec_t a, input vec_t b, input int hold);
        bit ok;
        issueReq(d, a, ok);
        if (!ok) return;
        waitRsp(d, a.name);
        holdCheck(d, a, hold);
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1; req_we[d] = b.we; req_access[d] = b.acc;
        req_addr[d] = b.addr; req_wdata[d] = b.wdata;
        #1;
        checkOutput({b.name, "_b2b_rdy"}, req_ready[d], 1);
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        checkOutput({a.name, "_vdrop"}, rsp_valid[d], 0);
        waitRsp(d, b.name);
        holdCheck(d, b, 0);
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        vec_t w;
        bit ok;
        logic [31:0] dummy_rd;
        logic dummy_err;

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_access[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_req_ready", req_ready[d], 0);
            checkOutput("rst_rsp_valid", rsp_valid[d], 0);
            checkOutput("rst_rsp_rdata", rsp_rdata[d], 0);
            checkOutput("rst_rsp_err", rsp_err[d], 0);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) checkOutput("post_rst_ready", req_ready[d], 1);

        tbl.push_back(mk("sw_10",    1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0));
        tbl.push_back(mk("lw_10",    0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk("lb_13",    0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0));
        tbl.push_back(mk("lbu_13",   0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0));
        tbl.push_back(mk("lh_12",    0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 0));
        tbl.push_back(mk("lhu_10",   0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl.push_back(mk("lh_11",    0, 3'b001, 32'h11,   32'h0,        32'h0,        1));
`else
        tbl.push_back(mk("lh_11",    0, 3'b001, 32'h11,   32'h0,        32'hFFFFBEEF, 0));
`endif
        tbl.push_back(mk("sb_11",    1, 3'b000, 32'h11,   32'h55,       32'h0,        0));
        tbl.push_back(mk("lw_10b",   0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl.push_back(mk("lw_12",    0, 3'b010, 32'h12,   32'h0,        32'h0,        1));
`else
        tbl.push_back(mk("lw_12",    0, 3'b010, 32'h12,   32'h0,        32'hDEAD55EF, 0));
`endif
        tbl.push_back(mk("sw_0",     1, 3'b010, 32'h0,    32'h12345678, 32'h0,        0));
        tbl.push_back(mk("sw_oor",   1, 3'b010, 32'h2000, 32'hCAFEF00D, 32'h0,        1));
        tbl.push_back(mk("lw_0a",    0, 3'b010, 32'h0,    32'h0,        32'h12345678, 0));
        tbl.push_back(mk("ld_c011",  0, 3'b011, 32'h0,    32'h0,        32'h0,        1));
        tbl.push_back(mk("st_c100",  1, 3'b100, 32'h0,    32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk("st_c110",  1, 3'b110, 32'h0,    32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk("lw_0b",    0, 3'b010, 32'h0,    32'h0,        32'h12345678, 0));
        tbl.push_back(mk("sh_2",     1, 3'b001, 32'h2,    32'h0000A5A5, 32'h0,        0));
        tbl.push_back(mk("lw_0c",    0, 3'b010, 32'h0,    32'h0,        32'hA5A55678, 0));
        tbl.push_back(mk("ld_c111",  0, 3'b111, 32'h0,    32'h0,        32'h0,        1));
        tbl.push_back(mk("lw_hiaddr",0, 3'b010, 32'h80000000, 32'h0,    32'h0,        1));

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < tbl.size(); i++) begin
                modelAccess(d, tbl[i].we, tbl[i].acc, tbl[i].addr, tbl[i].wdata, dummy_rd, dummy_err);
                applyStimulus(d, tbl[i], (d == 1) ? (i % 3) : 0);
            end
        end

        mkModel(1, "hs_lw10", 0, 3'b010, 32'h10, 32'h0, v);
        mkModel(1, "hs_lw0",  0, 3'b010, 32'h0,  32'h0, w);
        backToBack(1, v, w, 4);

        for (int d = 0; d < 2; d++) begin
            mkModel(d, "b2b_sw20", 1, 3'b010, 32'h20, 32'h0BADF00D, v);
            mkModel(d, "b2b_lw20", 0, 3'b010, 32'h20, 32'h0,        w);
            backToBack(d, v, w, 0);
        end

        v = mk("rst_sw0", 1, 3'b010, 32'h0, 32'h11111111, 32'h0, 0);
        issueReq(1, v, ok);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", req_ready[1], 0);
        checkOutput("midrst_valid", rsp_valid[1], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("after_rst_ready", req_ready[1], 1);
        checkOutput("after_rst_valid", rsp_valid[1], 0);
        mkModel(1, "rst_lw0", 0, 3'b010, 32'h0, 32'h0, v);
        applyStimulus(1, v, 0);

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 64; a += 4) begin
                mkModel(d, "rnd_fill", 1, 3'b010, 32'(a), $urandom, v);
                applyStimulus(d, v, 0);
            end
            for (int n = 0; n < 40; n++) begin
                logic [31:0] addr;
                addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) addr = addr + 32'h2000;
                mkModel(d, "rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        addr, $urandom, v);
                applyStimulus(d, v, $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
